timer_sequencer: RTL
====================

Name: timer_sequencer

Overview:
- Run/pause/stop controller for the two-digit BCD timer shown on the 7-segment pair.
- Takes one raw active-low keypad line and debounces it into press and long-press events.
- Sequences either an up count (00-59, wrapping) or a down count from a BCD preset to 00.
- Time-multiplexes the two digits onto a shared 4-bit digit bus for the segment decoder.
- Runs entirely on CLK. Derived timing is one-cycle enable strobes, never derived clocks.

Parameters:
- TICK_DIV, 16777216: CLK cycles per count step; strobe at count TICK_DIV-1.
- DEB_DIV, 262144: CLK cycles per key sample.
- SCAN_DIV, 2048: CLK cycles per digit-select toggle.
- LONG_SAMPLES, 64: consecutive low key samples that form a long press.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-low reset; clears all state.
- ROW0  in  1  raw key, active-low, asynchronous to CLK.
- MODE  in  1  1 = up count 00-59; 0 = down count from PRESET.
- PRESET  in  8  BCD down-count start value.
- COL0  out  1  keypad column drive, constant 0.
- BCD  out  8  current count, BCD.
- RUN  out  1  high in RUN state.
- DONE  out  1  high in DONE state.
- BLANK  out  1  digit blank request, used for the pause blink.
- DIGIT_SEL  out  1  0 = ones digit shown, 1 = tens digit shown.
- DIGIT  out  4  BCD nibble for the segment decoder.

Behaviour:
- Reset values: BCD=8'h00, RUN=0, DONE=0, BLANK=0, DIGIT_SEL=0, DIGIT=4'h0, state IDLE, all dividers 0.
- Key path:
  - 2-flop synchroniser on ROW0.
  - Sampled on each deb strobe.
  - Debounced level goes low after 3 consecutive low samples and high after 3 consecutive high samples.
  - press: 1-CLK pulse on the debounced high-to-low edge.
  - long: 1-CLK pulse when the debounced level has been low for LONG_SAMPLES samples; at most one pulse per hold.
- PRESET sanitising: a ones nibble above 9 clamps to 9; a tens nibble above 5 clamps to 5.
- States: IDLE, RUN, PAUSE, DONE.
- IDLE:
  - Every cycle, BCD = 00 if MODE=1, otherwise the sanitised PRESET.
  - press: go to RUN; if MODE=0 and BCD==00, go to DONE instead.
- RUN:
  - The tick prescaler counts.
  - On the tick strobe, step BCD by one in the latched mode.
  - Up count: ones 9 rolls to 0 with a tens carry; 59 wraps to 00 and the state stays RUN.
  - Down count: ones 0 rolls to 9 with a tens borrow; when the step produces 00, go to DONE in that same cycle.
  - press: go to PAUSE.
- PAUSE:
  - Prescaler holds its value, so a resume keeps the partial period.
  - BCD holds.
  - BLANK = 1 while the prescaler MSB-equivalent half-period is set.
  - press: go to RUN.
- DONE: DONE=1, BCD holds 00; press: go to IDLE.
- Mode latching: MODE is latched on IDLE to RUN. MODE and PRESET changes outside IDLE are ignored.
- Prescaler clear: on entry to IDLE and on IDLE to RUN.
- Tick and press in the same cycle in RUN: the step is applied, then the state goes to PAUSE. A step reaching DONE wins over PAUSE.
- long in any state: go to IDLE and clear the prescaler. It overrides a press in the same cycle. The press already issued at the start of the hold has taken effect.
- BLANK = 0 outside PAUSE.
- Scan:
  - DIGIT_SEL toggles on each scan strobe, free-running in all states.
  - DIGIT = BCD[3:0] when DIGIT_SEL=0, else BCD[7:4]. It is a registered output, one cycle after DIGIT_SEL/BCD change.
- Reset mid-operation: immediate return to the reset values. No key event is generated on release after reset.

Decomposition:
- Package timer_pkg: state encoding (IDLE, RUN, PAUSE, DONE), BCD_MAX=8'h59, BCD_ZERO=8'h00, DEB_STABLE=3.
- Sub-module key_debounce (synchroniser, sampler, stable counter, press/long pulses), instantiated once.
- FSM, BCD step, prescalers and scan mux stay in timer_sequencer.

Test Plan (TICK_DIV=16, DEB_DIV=4, SCAN_DIV=2, LONG_SAMPLES=8):
- Up count from reset: MODE=1, press, run 60 ticks -> BCD counts 00,01..09,10..59 then 00; RUN stays 1.
- Down count: MODE=0, PRESET=8'h03, press -> BCD 03,02,01,00; DONE=1, RUN=0 in the tick cycle reaching 00; press -> IDLE with BCD=03.
- Bounce: ROW0 toggles low/high on alternate samples for 10 samples, then stays low -> exactly one press pulse, 3 samples after the stable low begins.
- Pause/resume: press at tick prescaler=10, second press after 100 cycles -> BCD frozen and BLANK toggling during PAUSE; next step 6 CLK after resume.
- Long press: in RUN at BCD=8'h27, hold ROW0 low for 8+ samples -> PAUSE on press, then IDLE with BCD=00 on the long pulse; single long pulse.
- Edge cases:
  - PRESET=8'hAF clamps to BCD=59 in IDLE.
  - PRESET=00 with MODE=0, then press -> DONE next cycle.
  - RESET low mid-RUN -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types, constants and BCD helpers for the two-digit run/pause/stop timer.
package timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam logic [7:0] BCD_MAX    = 8'h59;
   localparam logic [7:0] BCD_ZERO   = 8'h00;
   localparam int         DEB_STABLE = 3;

   typedef struct packed {
      logic press;
      logic lng;
   } key_evt_t;

   function automatic logic [7:0] bcd_inc(input logic [7:0] b);
      logic [7:0] r;
      if (b == BCD_MAX)          r = BCD_ZERO;
      else if (b[3:0] == 4'd9)   r = {b[7:4] + 4'd1, 4'd0};
      else                       r = {b[7:4], b[3:0] + 4'd1};
      return r;
   endfunction

   function automatic logic [7:0] bcd_dec(input logic [7:0] b);
      logic [7:0] r;
      if (b[3:0] == 4'd0) r = {b[7:4] - 4'd1, 4'd9};
      else                r = {b[7:4], b[3:0] - 4'd1};
      return r;
   endfunction

   function automatic logic [7:0] bcd_clamp(input logic [7:0] b);
      return {(b[7:4] > 4'd5) ? 4'd5 : b[7:4], (b[3:0] > 4'd9) ? 4'd9 : b[3:0]};
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronises the raw active-low key, debounces it on a slow sample strobe
// and emits one-cycle press and long-press events.
module key_debounce
   import timer_pkg::*;
#(
   parameter int DEB_DIV      = 262144,
   parameter int LONG_SAMPLES = 64
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     key_n,
   output key_evt_t evt
);

   localparam int DW = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
   localparam int LW = $clog2(LONG_SAMPLES + 1);
   localparam int SW = $clog2(DEB_STABLE);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_DIV - 1);
   localparam logic [LW-1:0] LONG_LAST = LW'(LONG_SAMPLES);

   logic [1:0]    sync_q, sync_d;
   logic [DW-1:0] deb_cnt_q, deb_cnt_d;
   logic [SW-1:0] stab_cnt_q, stab_cnt_d;
   logic [LW-1:0] low_cnt_q, low_cnt_d;
   logic          level_q, level_d;
   key_evt_t      evt_q, evt_d;
   logic          stb;

   always_comb begin
      sync_d     = {sync_q[0], key_n};
      stb        = (deb_cnt_q == DEB_LAST);
      deb_cnt_d  = stb ? '0 : deb_cnt_q + DW'(1);
      level_d    = level_q;
      stab_cnt_d = stab_cnt_q;
      low_cnt_d  = low_cnt_q;
      evt_d      = '0;
      if (stb) begin
         // Count samples that disagree with the current level; any agreeing sample restarts the run.
         if (sync_q[1] == level_q) begin
            stab_cnt_d = '0;
         end else if (stab_cnt_q == SW'(DEB_STABLE - 1)) begin
            level_d    = sync_q[1];
            stab_cnt_d = '0;
         end else begin
            stab_cnt_d = stab_cnt_q + SW'(1);
         end
         if (!level_q) begin
            if (low_cnt_q != LONG_LAST) low_cnt_d = low_cnt_q + LW'(1);
            evt_d.lng = (low_cnt_q == LONG_LAST - LW'(1));
         end else begin
            low_cnt_d = '0;
         end
      end
      evt_d.press = level_q & ~level_d;
   end

   // Key idles high, so the synchroniser and level reset high: no event after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q     <= 2'b11;
         deb_cnt_q  <= '0;
         stab_cnt_q <= '0;
         low_cnt_q  <= '0;
         level_q    <= 1'b1;
         evt_q      <= '0;
      end else begin
         sync_q     <= sync_d;
         deb_cnt_q  <= deb_cnt_d;
         stab_cnt_q <= stab_cnt_d;
         low_cnt_q  <= low_cnt_d;
         level_q    <= level_d;
         evt_q      <= evt_d;
      end
   end

   assign evt = evt_q;

endmodule

// File: rtl/timer_sequencer.sv
// Two-digit BCD timer: key-driven run/pause/stop FSM, up/down BCD stepping,
// pause blink and time-multiplexed digit output.
module timer_sequencer
   import timer_pkg::*;
#(
   parameter int TICK_DIV     = 16777216,
   parameter int DEB_DIV      = 262144,
   parameter int SCAN_DIV     = 2048,
   parameter int LONG_SAMPLES = 64
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       ROW0,
   input  logic       MODE,
   input  logic [7:0] PRESET,
   output logic       COL0,
   output logic [7:0] BCD,
   output logic       RUN,
   output logic       DONE,
   output logic       BLANK,
   output logic       DIGIT_SEL,
   output logic [3:0] DIGIT
);

   localparam int TW = $clog2(TICK_DIV);
   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
   localparam logic [TW-1:0] BLINK_HALF = TW'(TICK_DIV / 2);
   localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV - 1);

   state_e        state_q, state_d;
   logic [7:0]    bcd_q, bcd_d;
   logic          mode_q, mode_d;
   logic [TW-1:0] tick_cnt_q, tick_cnt_d;
   logic [TW-1:0] blink_cnt_q, blink_cnt_d;
   logic [CW-1:0] scan_cnt_q, scan_cnt_d;
   logic          sel_q, sel_d;
   logic [3:0]    digit_q, digit_d;
   key_evt_t      key_evt;
   logic [7:0]    idle_bcd, bcd_step;
   logic          tick;

   key_debounce #(
      .DEB_DIV      (DEB_DIV),
      .LONG_SAMPLES (LONG_SAMPLES)
   ) u_key (
      .clk   (CLK),
      .rst_n (RESET),
      .key_n (ROW0),
      .evt   (key_evt)
   );

   always_comb begin
      idle_bcd    = MODE ? BCD_ZERO : bcd_clamp(PRESET);
      bcd_step    = mode_q ? bcd_inc(bcd_q) : bcd_dec(bcd_q);
      tick        = (state_q == ST_RUN) && (tick_cnt_q == TICK_LAST);
      state_d     = state_q;
      bcd_d       = bcd_q;
      mode_d      = mode_q;
      tick_cnt_d  = tick_cnt_q;
      blink_cnt_d = '0;
      case (state_q)
         ST_IDLE: begin
            bcd_d      = idle_bcd;
            tick_cnt_d = '0;
            if (key_evt.press) begin
               mode_d = MODE;
               if (!MODE && bcd_q == BCD_ZERO) begin
                  state_d = ST_DONE;
                  bcd_d   = BCD_ZERO;
               end else begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            // A press that pauses freezes the prescaler so resume keeps the partial period.
            if (tick) begin
               tick_cnt_d = '0;
               bcd_d      = bcd_step;
            end else if (!key_evt.press) begin
               tick_cnt_d = tick_cnt_q + TW'(1);
            end
            if (tick && !mode_q && bcd_step == BCD_ZERO) state_d = ST_DONE;
            else if (key_evt.press)                      state_d = ST_PAUSE;
         end
         ST_PAUSE: begin
            blink_cnt_d = (blink_cnt_q == TICK_LAST) ? '0 : blink_cnt_q + TW'(1);
            if (key_evt.press) state_d = ST_RUN;
         end
         ST_DONE: begin
            if (key_evt.press) begin
               state_d = ST_IDLE;
               bcd_d   = idle_bcd;
            end
         end
      endcase
      if (key_evt.lng) begin
         state_d    = ST_IDLE;
         bcd_d      = idle_bcd;
         tick_cnt_d = '0;
      end
   end

   always_comb begin
      scan_cnt_d = (scan_cnt_q == SCAN_LAST) ? '0 : scan_cnt_q + CW'(1);
      sel_d      = (scan_cnt_q == SCAN_LAST) ? ~sel_q : sel_q;
      digit_d    = sel_q ? bcd_q[7:4] : bcd_q[3:0];
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q     <= ST_IDLE;
         bcd_q       <= BCD_ZERO;
         mode_q      <= 1'b0;
         tick_cnt_q  <= '0;
         blink_cnt_q <= '0;
         scan_cnt_q  <= '0;
         sel_q       <= 1'b0;
         digit_q     <= 4'h0;
      end else begin
         state_q     <= state_d;
         bcd_q       <= bcd_d;
         mode_q      <= mode_d;
         tick_cnt_q  <= tick_cnt_d;
         blink_cnt_q <= blink_cnt_d;
         scan_cnt_q  <= scan_cnt_d;
         sel_q       <= sel_d;
         digit_q     <= digit_d;
      end
   end

   assign COL0      = 1'b0;
   assign BCD       = bcd_q;
   assign RUN       = (state_q == ST_RUN);
   assign DONE      = (state_q == ST_DONE);
   assign BLANK     = (state_q == ST_PAUSE) && (blink_cnt_q >= BLINK_HALF);
   assign DIGIT_SEL = sel_q;
   assign DIGIT     = digit_q;

endmodule
